// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bus master sitting in front of the 32x8 data memory.
// Accepts load/store requests over a valid/ready handshake. It drives the
// memory address and write enable and owns the controller side of the shared
// tristate data bus. Read data comes back as one-cycle response pulses.
// Stores are single beat. Loads are 1..MAXLEN beat incrementing bursts that
// wrap modulo 2^AW.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (accept on valid & ready)
//   req_write             1 = store, 0 = load
//   req_addr, req_len     start address, read beats minus one (loads only)
//   req_wdata             store data
//   rsp_valid, rsp_rdata  one pulse per returned read beat, with its data
//   wr_done               one-cycle pulse when a store has been committed
//   busy                  inverse of req_ready
//   mem_addr              memory address
//   mem_write_en          memory write enable
//   mem_data              shared data bus, driven only while mem_write_en=1
module mem_bus_ctrl #(
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter int MAXLEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_len,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          wr_done,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_write_en,
    inout  wire  [DW-1:0] mem_data
);

    localparam int CW = $clog2(MAXLEN);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DRAIN = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [AW-1:0]   addr_r, addr_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic            we_r, we_s;
    logic [DW-1:0]   wdata_r, wdata_s;
    // live_r: the address presented in the current cycle is a real read beat.
    logic            live_r, live_s;
    // cap_r: the memory is driving data for a beat this cycle; capture it at the edge.
    logic            cap_r;
    logic            rsp_valid_r;
    logic [DW-1:0]   rdata_r, rdata_s;
    logic            wr_done_r, wr_done_s;
    logic            ready_r, ready_s;
    logic            busy_r;

    // Next-state and next-register values for the request FSM and read pipeline
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        cnt_s     = cnt_r;
        we_s      = 1'b0;
        wdata_s   = wdata_r;
        live_s    = 1'b0;
        wr_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && ready_r) begin
                    addr_s = req_addr;
                    if (req_write) begin
                        we_s    = 1'b1;
                        wdata_s = req_wdata;
                        state_s = WR;
                    end else begin
                        cnt_s  = CW'(req_len);
                        live_s = 1'b1;
                        if (req_len == 2'd0) begin
                            state_s = RD_DRAIN;
                        end else begin
                            state_s = RD_ISSUE;
                        end
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                // The memory commits on this edge. Dropping we_r also releases the bus.
                wr_done_s = 1'b1;
                state_s   = IDLE;
            end
            RD_ISSUE: begin
                addr_s = addr_r + {{(AW-1){1'b0}}, 1'b1};
                cnt_s  = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                live_s = 1'b1;
                if (cnt_r == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_s = RD_DRAIN;
                end else begin
                    state_s = RD_ISSUE;
                end
            end
            RD_DRAIN: begin
                // First cycle still presents the last beat. The second cycle waits for its capture.
                if (live_r) begin
                    state_s = RD_DRAIN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (cap_r) begin
            rdata_s = mem_data;
        end else begin
            rdata_s = rdata_r;
        end

        ready_s = (state_s == IDLE);
    end

    // State and output registers, all cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            addr_r      <= {AW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            we_r        <= 1'b0;
            wdata_r     <= {DW{1'b0}};
            live_r      <= 1'b0;
            cap_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
            rdata_r     <= {DW{1'b0}};
            wr_done_r   <= 1'b0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            cnt_r       <= cnt_s;
            we_r        <= we_s;
            wdata_r     <= wdata_s;
            live_r      <= live_s;
            cap_r       <= live_r;
            rsp_valid_r <= cap_r;
            rdata_r     <= rdata_s;
            wr_done_r   <= wr_done_s;
            ready_r     <= ready_s;
            busy_r      <= !ready_s;
        end
    end

    assign req_ready    = ready_r;
    assign busy         = busy_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rdata_r;
    assign wr_done      = wr_done_r;
    assign mem_addr     = addr_r;
    assign mem_write_en = we_r;
    // Bus drive and write enable come from the same register, so they cannot overlap.
    assign mem_data     = we_r ? wdata_r : {DW{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl. It contains a behavioural model of the
// 32x8 memory. A transaction-level model turns each accepted request into
// per-cycle expectations (ready, write enable, address, responses), and these
// are compared against the DUT on every cycle.
module tb_mem_bus_ctrl;
    localparam int NCYC = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [4:0] req_addr;
    logic [1:0] req_len;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       wr_done;
    logic       busy;
    logic [4:0] mem_addr;
    logic       mem_write_en;
    wire  [7:0] mem_data;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.AW(5), .DW(8), .MAXLEN(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .wr_done(wr_done), .busy(busy), .mem_addr(mem_addr),
        .mem_write_en(mem_write_en), .mem_data(mem_data)
    );

    // Memory model: registered read, combinational bus drive, write on write_en edges
    logic [7:0] mem [32];
    logic [7:0] mm  [32];
    logic [7:0] rd_q;
    logic       init_load;
    always @(posedge clk) begin
        if (init_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= mm[i];
        end else if (mem_write_en) begin
            mem[mem_addr] <= mem_data;
        end else begin
            rd_q <= mem[mem_addr];
        end
    end
    assign mem_data = mem_write_en ? 8'bz : rd_q;

    // Expectations indexed by cycle number (cycle k follows clock edge k)
    bit         e_av  [NCYC];
    logic [4:0] e_addr[NCYC];
    bit         e_we  [NCYC];
    logic [7:0] e_bus [NCYC];
    bit         e_rsp [NCYC];
    logic [7:0] e_rd  [NCYC];
    bit         e_wd  [NCYC];
    bit         e_rst [NCYC];
    int         busy_until;
    int         cyc;
    int         x_from;
    bit         accepted;
    int         errors;
    int         checks;
    logic [7:0] log_d[$];
    int         log_c[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Turns an accepted request at edge t into expected per-cycle behaviour
    task automatic sched(input int t, input bit w, input logic [4:0] a,
                         input logic [1:0] l, input logic [7:0] d);
        if (w) begin
            e_we[t]   = 1'b1;
            e_av[t]   = 1'b1;
            e_addr[t] = a;
            e_bus[t]  = d;
            e_wd[t+1] = 1'b1;
            mm[a]     = d;
            busy_until = t + 1;
        end else begin
            for (int i = 0; i <= int'(l); i++) begin
                e_av[t+i]   = 1'b1;
                e_addr[t+i] = 5'((int'(a) + i) % 32);
                e_rsp[t+i+2] = 1'b1;
                e_rd[t+i+2]  = mm[(int'(a) + i) % 32];
            end
            busy_until = t + int'(l) + 2;
        end
    endtask

    task automatic check_cycle(input int k);
        chk("req_ready", 32'(req_ready), 32'(k >= busy_until));
        chk("busy", 32'(busy), 32'(k < busy_until));
        chk("mem_write_en", 32'(mem_write_en), 32'(e_we[k]));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp[k]));
        chk("wr_done", 32'(wr_done), 32'(e_wd[k]));
        if (e_rsp[k]) chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rd[k]));
        if (e_av[k])  chk("mem_addr", 32'(mem_addr), 32'(e_addr[k]));
        if (e_we[k])  chk("bus_wdata", 32'(mem_data), 32'(e_bus[k]));
        if (e_rst[k]) begin
            chk("rst_rdata", 32'(rsp_rdata), 32'd0);
            chk("rst_addr", 32'(mem_addr), 32'd0);
        end
        if (k >= x_from) chk("bus_no_x", 32'((^mem_data) === 1'bx), 32'd0);
        if (rsp_valid === 1'b1) begin
            log_d.push_back(rsp_rdata);
            log_c.push_back(k);
        end
    endtask

    // Advance one clock edge, applying the model for that edge, then check the new cycle
    task automatic step();
        int t;
        t = cyc + 1;
        if (rst) begin
            for (int k = t; k < t + 8; k++) begin
                e_av[k] = 1'b0; e_we[k] = 1'b0; e_rsp[k] = 1'b0; e_wd[k] = 1'b0;
            end
            e_rst[t]   = 1'b1;
            busy_until = t;
        end else if (req_valid && cyc >= busy_until) begin
            sched(t, req_write, req_addr, req_len, req_wdata);
            accepted = 1'b1;
        end
        @(posedge clk);
        cyc = t;
        @(negedge clk);
        check_cycle(cyc);
    endtask

    // Offer one request and hold it until the model says it is taken
    task automatic do_req(input bit w, input logic [4:0] a, input logic [1:0] l,
                          input logic [7:0] d, output int tacc);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
        accepted = 1'b0;
        tacc = 0;
        for (int n = 0; n < 20 && !accepted; n++) begin
            tacc = cyc + 1;
            step();
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout cycle=%0d got=not_accepted expected=accepted", cyc);
        end
        // Scramble the request fields to show they are ignored once accepted
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 5'($urandom);
        req_len   = 2'($urandom);
        req_wdata = 8'($urandom);
    endtask

    int t0, t1, sz, nlog;

    initial begin
        errors = 0; checks = 0; cyc = 0; busy_until = 0; x_from = 4;
        for (int i = 0; i < 32; i++) mm[i] = 8'($urandom);
        init_load = 1'b1;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 5'd0; req_len = 2'd0; req_wdata = 8'd0;
        step();
        step();
        init_load = 1'b0;
        rst = 1'b0;
        step();

        // Store 0xA5 at 5, then read it back
        do_req(1'b1, 5'd5, 2'd2, 8'hA5, t0);
        step();
        do_req(1'b0, 5'd5, 2'd0, 8'h00, t1);
        step(); step();
        chk("store_readback", 32'(log_d[$]), 32'hA5);
        chk("load_latency", 32'(log_c[$]), 32'(t1 + 2));

        // Single-beat load of a preloaded location
        do_req(1'b1, 5'h10, 2'd0, 8'h3C, t0);
        do_req(1'b0, 5'h10, 2'd0, 8'h00, t1);
        step(); step();
        chk("single_load", 32'(log_d[$]), 32'h3C);

        // Burst that wraps from 31 to 0
        do_req(1'b1, 5'd30, 2'd0, 8'h11, t0);
        do_req(1'b1, 5'd31, 2'd0, 8'h22, t0);
        do_req(1'b1, 5'd0,  2'd0, 8'h33, t0);
        do_req(1'b1, 5'd1,  2'd0, 8'h44, t0);
        do_req(1'b0, 5'd30, 2'd3, 8'h00, t1);
        for (int i = 0; i < 6; i++) step();
        sz = log_d.size();
        chk("wrap_b0", 32'(log_d[sz-4]), 32'h11);
        chk("wrap_b1", 32'(log_d[sz-3]), 32'h22);
        chk("wrap_b2", 32'(log_d[sz-2]), 32'h33);
        chk("wrap_b3", 32'(log_d[sz-1]), 32'h44);
        chk("wrap_first_cycle", 32'(log_c[sz-4]), 32'(t1 + 2));
        chk("wrap_last_cycle", 32'(log_c[sz-1]), 32'(t1 + 5));

        // Back-to-back store then load with valid held continuously
        do_req(1'b1, 5'd2, 2'd1, 8'h7E, t0);
        do_req(1'b0, 5'd2, 2'd0, 8'h00, t1);
        step(); step();
        chk("b2b_data", 32'(log_d[$]), 32'h7E);
        chk("b2b_accept", 32'(t1), 32'(t0 + 2));

        // Second request held valid throughout a 4-beat burst
        do_req(1'b0, 5'd8, 2'd3, 8'h00, t0);
        do_req(1'b0, 5'd20, 2'd1, 8'h00, t1);
        for (int i = 0; i < 4; i++) step();
        chk("hold_second_rsp", 32'(log_c[$-1]), 32'(t0 + 8));

        // Reset during the second beat of a 4-beat burst
        do_req(1'b0, 5'd12, 2'd3, 8'h00, t0);
        step(); step(); step();
        nlog = log_d.size();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 6; i++) step();
        chk("rst_no_more_rsp", 32'(log_d.size()), 32'(nlog));

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            do_req(1'($urandom), 5'($urandom), 2'($urandom), 8'($urandom), t0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
        for (int i = 0; i < 8; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Bus master placed directly upstream of the 32x8 data memory.
- Accepts load/store requests from the CPU datapath through a valid/ready handshake.
- Drives the memory's address and write_en, owns the tristate side of the shared 8-bit data bus, and returns read data as one-cycle response pulses.
- Supports single-beat writes and 1-4 beat incrementing read bursts, so instruction fetch and operand loads share one port.

Parameters:
- AW, 5, memory address width (32 locations)
- DW, 8, data bus width
- MAXLEN, 4, maximum read beats per request

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_addr  input  AW  start address
- req_len  input  2  read beats minus one (0..3); ignored for writes
- req_wdata  input  DW  store data
- rsp_valid  output  1  one-cycle pulse per returned read beat
- rsp_rdata  output  DW  read data, valid while rsp_valid=1
- wr_done  output  1  one-cycle pulse when a store has been committed
- busy  output  1  equals !req_ready
- mem_addr  output  AW  memory address
- mem_write_en  output  1  memory write enable
- mem_data  inout  DW  shared data bus; driven with the write data only while mem_write_en=1, otherwise high-Z

Behaviour:
- Acceptance: a request is accepted on a rising edge where req_valid=1 and req_ready=1. Call that edge P0.
- Reset values: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, wr_done=0, mem_addr=0, mem_write_en=0, mem_data=Z.
- Memory timing contract: the memory registers mem[mem_addr] on each edge where mem_write_en=0 and drives that value onto the bus combinationally. It commits a write on an edge where mem_write_en=1.
- States: IDLE, WR, RD_ISSUE, RD_DRAIN.
- IDLE: req_ready=1.
  - On accept of a store: from P0, mem_addr=req_addr, mem_write_en=1, bus driven with req_wdata. Next state WR.
  - On accept of a load: from P0, mem_addr=req_addr, mem_write_en=0, beat counter=req_len. Next state RD_ISSUE, or RD_DRAIN if req_len=0.
- WR: the memory commits at P1.
  - From P1: mem_write_en=0, bus released, wr_done=1 for exactly one cycle, state returns to IDLE. req_ready is 1 again from P1.
  - Bus release and write_en deassertion come from the same register, so the two drivers never overlap.
- RD_ISSUE: on each edge, mem_addr increments by 1 and the counter decrements.
  - Address wrap: 31 -> 0, modulo 2^AW.
  - When the counter reaches 0 after the increment, go to RD_DRAIN.
- Read pipeline:
  - Data for the address presented during cycle n is captured from mem_data at the end of cycle n+1.
  - rsp_valid=1 with rsp_rdata during cycle n+2. Read latency is therefore 2 cycles from address presentation.
  - A burst returns consecutive rsp_valid pulses with no gaps, in address order.
- RD_DRAIN: hold mem_addr until the final beat is captured, then go to IDLE.
  - The last rsp_valid pulse coincides with the first cycle of req_ready=1.
  - No response backpressure exists; the consumer must take every beat.
- req_ready is 0 in all states except IDLE. Requests offered while busy are held by the requester and are not dropped.
- req_len is sampled only at P0. Later input changes have no effect on the transfer in flight.
- rsp_valid and wr_done are never high simultaneously.
- Reset mid-operation: all state returns to reset values on the next edge.
  - Outstanding beats are discarded and no rsp_valid follows.
  - A write whose P1 has not occurred is aborted, and mem_write_en drops on the reset edge.
- mem_data is never driven while mem_write_en=0, including during reset.

Test Plan:
- Store: req (write, addr 5, data 0xA5) -> mem_write_en=1 for exactly one cycle, wr_done pulse at P1, bus Z afterwards; a load from addr 5 returns rsp_rdata=0xA5 two cycles after P0.
- Single load: preload mem[0x10]=0x3C; load addr 0x10 len 0 -> rsp_valid single pulse in cycle P0+2 with 0x3C; req_ready=0 during P0..P0+1.
- Burst wrap: preload mem[30]=0x11, mem[31]=0x22, mem[0]=0x33, mem[1]=0x44; load addr 30 len 3 -> mem_addr sequence 30,31,0,1; four back-to-back rsp_valid pulses returning 0x11, 0x22, 0x33, 0x44.
- Back-to-back: store (addr 2, 0x7E) held valid together with a following load from addr 2 -> load accepted the edge after the store commits; returns 0x7E; bus monitor reports no X/contention at the write-to-read turnaround.
- Busy hold: assert a second req_valid throughout a len-3 burst -> not accepted until req_ready returns, then accepted exactly once.
- Reset mid-burst: assert rst during the second beat of a len-3 burst -> next cycle all outputs at reset values, no further rsp_valid, req_ready=1, mem_data=Z.
